capt_op_feeder: RTL and testbench

Upstream feeder for `capt_count`.
- Accepts 2-bit ops from a producer through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues the buffered ops to `capt_count` on its `op`/`capture` inputs, at most one per clock.
- Honours `capt_count`'s `full` output as back-pressure, so no op is dropped while the counter is full.

---
 rtl/capt_op_feeder.sv | 113 +++++++++++
 tb/tb_capt_op_feeder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/capt_op_feeder.sv
// capt_op_feeder: DEPTH-entry op FIFO that feeds capt_count's op/capture inputs
// at most one op per clock, stalling while capt_count reports full.
// Optional feature macro: CAPT_OP_FEEDER_STATS_EN adds a saturating issued_cnt output.
module capt_op_feeder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    output logic             in_ready,
    input  logic             full,
    output logic [1:0]       op,
    output logic             capture,
    output logic             empty,
    output logic [1:0]       state
`ifdef CAPT_OP_FEEDER_STATS_EN
    ,
    output logic [CNT_W-1:0] issued_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t        state_q;
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    op_q;
    logic          capture_q;
    logic          push;
    logic          issue;

    assign in_ready = rst_n && (count_q != FULL_CNT);
    assign empty    = (count_q == '0);
    assign op       = op_q;
    assign capture  = capture_q;
    assign state    = state_q;

    // Handshake decode and next FIFO pointers/occupancy from pre-edge values.
    always_comb begin
        push    = in_valid && in_ready;
        issue   = (count_q != '0) && !full;
        rd_d    = issue ? rd_q + AW'(1) : rd_q;
        wr_d    = push  ? wr_q + AW'(1) : wr_q;
        count_d = count_q;
        if (push && !issue) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push && issue) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // FIFO storage; contents are meaningless after reset since pointers clear.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_q] <= in_op;
        end
    end

    // Issue FSM with registered op/capture and FIFO bookkeeping.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            capture_q <= 1'b0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            if (issue) begin
                op_q      <= mem_q[rd_q];
                capture_q <= 1'b1;
                state_q   <= ISSUE;
            end else begin
                capture_q <= 1'b0;
                state_q   <= (count_q != '0) ? STALL : IDLE;
            end
        end
    end

`ifdef CAPT_OP_FEEDER_STATS_EN
    logic [CNT_W-1:0] issued_cnt_q;

    assign issued_cnt = issued_cnt_q;

    // Saturating count of issued ops.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt_q <= '0;
        end else if (issue && (issued_cnt_q != '1)) begin
            issued_cnt_q <= issued_cnt_q + CNT_W'(1);
        end
    end
`else
    // CNT_W only sizes the stats counter; keep it referenced when that is compiled out.
    logic stats_unused;
    assign stats_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_capt_op_feeder.sv
// Testbench for capt_op_feeder: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_capt_op_feeder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b1;
    logic [1:0]       in_op = 2'b11;
    logic             in_ready;
    logic             full = 1'b0;
    logic [1:0]       op;
    logic             capture;
    logic             empty;
    logic [1:0]       state;
`ifdef CAPT_OP_FEEDER_STATS_EN
    logic [CNT_W-1:0] issued_cnt;
`endif

    int checks = 0;
    int errors = 0;

    capt_op_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_op      (in_op),
        .in_ready   (in_ready),
        .full       (full),
        .op         (op),
        .capture    (capture),
        .empty      (empty),
        .state      (state)
`ifdef CAPT_OP_FEEDER_STATS_EN
        ,
        .issued_cnt (issued_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending ops.
    logic [1:0]       mq[$];
    logic [1:0]       m_op;
    logic             m_cap;
    logic [1:0]       m_state;
    logic [CNT_W-1:0] m_iss;

    initial begin
        int  n;
        bit  m_push, m_issue;
        m_op = '0; m_cap = 1'b0; m_state = 2'b00; m_iss = '0;
        forever begin
            @(posedge clock);
            if (!rst_n) begin
                mq.delete();
                m_op = '0; m_cap = 1'b0; m_state = 2'b00; m_iss = '0;
            end else begin
                n       = mq.size();
                m_push  = in_valid && (n != DEPTH);
                m_issue = (n != 0) && !full;
                if (m_issue) begin
                    m_op  = mq.pop_front();
                    m_cap = 1'b1;
                    if (m_iss != '1) m_iss = m_iss + 1'b1;
                    m_state = 2'b01;
                end else begin
                    m_cap   = 1'b0;
                    m_state = (n != 0) ? 2'b10 : 2'b00;
                end
                if (m_push) mq.push_back(in_op);
            end
            #1;
            check("model_op", 32'(op), 32'(m_op));
            check("model_capture", 32'(capture), 32'(m_cap));
            check("model_state", 32'(state), 32'(m_state));
            check("model_in_ready", 32'(in_ready), 32'(rst_n && (mq.size() != DEPTH)));
            check("model_empty", 32'(empty), 32'(mq.size() == 0));
`ifdef CAPT_OP_FEEDER_STATS_EN
            check("model_issued_cnt", 32'(issued_cnt), 32'(m_iss));
`endif
        end
    end

    logic [1:0] bp_ops [5];
    logic [1:0] op_a, op_b, op_c;

    initial begin
        bp_ops[0] = 2'b01; bp_ops[1] = 2'b11; bp_ops[2] = 2'b00;
        bp_ops[3] = 2'b10; bp_ops[4] = 2'b01;
        op_a = 2'b11; op_b = 2'b01; op_c = 2'b10;

        // Reset held one period with in_valid high.
        @(posedge clock); #2;
        check("rst_op", 32'(op), 32'h0);
        check("rst_capture", 32'(capture), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_state", 32'(state), 32'h0);
        @(negedge clock); rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clock); #2;
        check("rst_nothing_enqueued", 32'(empty), 32'h1);

        // Single op: push 10 at edge N.
        @(negedge clock); in_valid = 1'b1; in_op = 2'b10; full = 1'b0;
        @(negedge clock); in_valid = 1'b0;
        @(posedge clock); #2;
        check("single_capture", 32'(capture), 32'h1);
        check("single_op", 32'(op), 32'h2);
        check("single_state_issue", 32'(state), 32'h1);
        @(posedge clock); #2;
        check("single_capture_drop", 32'(capture), 32'h0);
        check("single_state_idle", 32'(state), 32'h0);

        // Burst 00,01,10,11 back-to-back.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i >= 2) begin
                check("burst_capture", 32'(capture), 32'h1);
                check("burst_op", 32'(op), 32'(i - 2));
            end
            if (i < 4) begin
                check("burst_in_ready", 32'(in_ready), 32'h1);
                in_valid = 1'b1; in_op = 2'(i);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clock);
        check("burst_end_capture", 32'(capture), 32'h0);

        // Back-pressure: five pushes into a four-entry FIFO with full high.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_op = bp_ops[i]; full = 1'b1;
        end
        check("bp_fifo_full_ready", 32'(in_ready), 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("bp_hold_ready", 32'(in_ready), 32'h0);
            check("bp_hold_capture", 32'(capture), 32'h0);
            check("bp_hold_state", 32'(state), 32'h2);
        end
        @(negedge clock); full = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            check("bp_drain_capture", 32'(capture), 32'h1);
            check("bp_drain_op", 32'(op), 32'(bp_ops[j]));
            if (j == 0) check("bp_ready_after_issue", 32'(in_ready), 32'h1);
            if (j == 1) in_valid = 1'b0;
        end
        @(negedge clock);
        check("bp_done_capture", 32'(capture), 32'h0);
        check("bp_done_state", 32'(state), 32'h0);

        // Push on an issuing edge with two entries queued, then a 3-cycle stall.
        @(negedge clock); full = 1'b1; in_valid = 1'b1; in_op = op_a;
        @(negedge clock); in_op = op_b;
        @(negedge clock); full = 1'b0; in_op = op_c;
        @(negedge clock);
        check("sim_capture", 32'(capture), 32'h1);
        check("sim_op", 32'(op), 32'(op_a));
        check("sim_not_empty", 32'(empty), 32'h0);
        in_valid = 1'b0; full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("stall_capture", 32'(capture), 32'h0);
            check("stall_op_held", 32'(op), 32'(op_a));
            check("stall_state", 32'(state), 32'h2);
            if (k == 2) full = 1'b0;
        end
        @(negedge clock);
        check("resume_op_b", 32'(op), 32'(op_b));
        check("resume_capture", 32'(capture), 32'h1);
        @(negedge clock);
        check("resume_op_c", 32'(op), 32'(op_c));
        @(negedge clock);
        check("resume_idle", 32'(capture), 32'h0);

        // Long burst: 300 ops, counter saturates.
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            check("long_in_ready", 32'(in_ready), 32'h1);
            in_valid = 1'b1; in_op = i[1:0];
        end
        @(negedge clock); in_valid = 1'b0;
        @(negedge clock);
`ifdef CAPT_OP_FEEDER_STATS_EN
        check("stats_saturated", 32'(issued_cnt), 32'hFF);
`endif

        // Reset in the middle of a burst.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); in_valid = 1'b1; in_op = 2'(3 - i);
        end
        check("midrst_pre_capture", 32'(capture), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_capture", 32'(capture), 32'h0);
        check("midrst_state", 32'(state), 32'h0);
        check("midrst_empty", 32'(empty), 32'h1);
`ifdef CAPT_OP_FEEDER_STATS_EN
        check("midrst_issued_cnt", 32'(issued_cnt), 32'h0);
`endif
        @(negedge clock); rst_n = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_capture", 32'(capture), 32'h0);
        check("post_rst_empty", 32'(empty), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
